// File: rtl/trap_pkg.sv
// rtl/trap_pkg.sv - shared types and constants for the machine-mode trap sequencer
package trap_pkg;

  localparam int TRAP_XLEN = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_COMMIT,
    ST_REDIRECT
  } trap_state_e;

  localparam logic [3:0] EXC_INSN_MISALIGNED  = 4'd0;
  localparam logic [3:0] EXC_ILLEGAL          = 4'd2;
  localparam logic [3:0] EXC_EBREAK           = 4'd3;
  localparam logic [3:0] EXC_LOAD_MISALIGNED  = 4'd4;
  localparam logic [3:0] EXC_STORE_MISALIGNED = 4'd6;
  localparam logic [3:0] EXC_ECALL_M          = 4'd11;

  localparam logic [3:0] IRQ_SW  = 4'd3;
  localparam logic [3:0] IRQ_TMR = 4'd7;
  localparam logic [3:0] IRQ_EXT = 4'd11;

  localparam int MIE_MSIE = 3;
  localparam int MIE_MTIE = 7;
  localparam int MIE_MEIE = 11;

  localparam logic [1:0] MTVEC_DIRECT   = 2'd0;
  localparam logic [1:0] MTVEC_VECTORED = 2'd1;

  function automatic logic [TRAP_XLEN-1:0] make_mcause(input logic is_irq, input logic [3:0] code);
    make_mcause = {is_irq, {(TRAP_XLEN-5){1'b0}}, code};
  endfunction

endpackage

// File: rtl/trap_sequencer_irq_sync.sv
// rtl/trap_sequencer_irq_sync.sv - flop-chain synchronizer for one asynchronous interrupt level
module irq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_sync
);

  logic [SYNC_STAGES-1:0] r_chain;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_chain <= '0;
    end else begin
      r_chain[0] <= i_async;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_chain[i] <= r_chain[i-1];
      end
    end
  end

  assign o_sync = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/trap_sequencer.sv
// rtl/trap_sequencer.sv - trap entry / MRET exit sequencer: arbitrate, drain, commit CSRs, redirect fetch
module trap_sequencer
  import trap_pkg::*;
#(
  parameter int XLEN        = TRAP_XLEN,
  parameter int SYNC_STAGES = 2,
  parameter int DRAIN_MAX   = 15
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_ext_irq,
  input  logic            i_sw_irq,
  input  logic            i_tmr_irq,
  input  logic            i_mstatus_mie,
  input  logic [XLEN-1:0] i_mie,
  input  logic [XLEN-1:0] i_mtvec,
  input  logic [XLEN-1:0] i_mepc,
  input  logic            i_exc_valid,
  input  logic [3:0]      i_exc_cause,
  input  logic [XLEN-1:0] i_exc_pc,
  input  logic [XLEN-1:0] i_exc_tval,
  input  logic            i_mret,
  input  logic [XLEN-1:0] i_next_pc,
  input  logic            i_pipe_empty,
  output logic            o_flush,
  output logic            o_trap_enter,
  output logic            o_trap_exit,
  output logic [XLEN-1:0] o_mepc,
  output logic [XLEN-1:0] o_mcause,
  output logic [XLEN-1:0] o_mtval,
  output logic            o_redirect_valid,
  output logic [XLEN-1:0] o_redirect_pc,
  output logic            o_busy
);

  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_MAX);

  trap_state_e     r_state;
  trap_state_e     w_state_next;
  logic            w_capture;
  logic            r_is_mret;
  logic            r_is_irq;
  logic [3:0]      r_code;
  logic [3:0]      r_drain_cnt;
  logic [XLEN-1:0] r_mepc;
  logic [XLEN-1:0] r_mcause;
  logic [XLEN-1:0] r_mtval;
  logic [XLEN-1:0] r_redirect_pc;

  logic            w_ext_s, w_sw_s, w_tmr_s;
  logic            w_ext_pend, w_sw_pend, w_tmr_pend, w_irq_any;
  logic [3:0]      w_irq_code;
  logic            w_take_irq, w_take_mret;
  logic [XLEN-1:0] w_base;
  logic [XLEN-1:0] w_target;
  logic            w_unused;

  irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ext (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_async(i_ext_irq), .o_sync(w_ext_s));
  irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sw (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_async(i_sw_irq), .o_sync(w_sw_s));
  irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_tmr (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_async(i_tmr_irq), .o_sync(w_tmr_s));

  assign w_ext_pend = w_ext_s & i_mie[MIE_MEIE] & i_mstatus_mie;
  assign w_sw_pend  = w_sw_s  & i_mie[MIE_MSIE] & i_mstatus_mie;
  assign w_tmr_pend = w_tmr_s & i_mie[MIE_MTIE] & i_mstatus_mie;
  assign w_irq_any  = w_ext_pend | w_sw_pend | w_tmr_pend;

  // Exception beats interrupt beats MRET; the losers are simply not captured.
  assign w_take_irq  = ~i_exc_valid & w_irq_any;
  assign w_take_mret = ~i_exc_valid & ~w_irq_any & i_mret;

  assign w_unused = ^{i_mie[XLEN-1:12], i_mie[10:8], i_mie[6:4], i_mie[2:0]};

  always_comb begin
    w_irq_code = IRQ_TMR;
    if (w_ext_pend) begin
      w_irq_code = IRQ_EXT;
    end else if (w_sw_pend) begin
      w_irq_code = IRQ_SW;
    end
  end

  assign w_base = {i_mtvec[XLEN-1:2], 2'b00};

  always_comb begin
    w_target = w_base;
    if (r_is_mret) begin
      w_target = {i_mepc[XLEN-1:2], 2'b00};
    end else if (r_is_irq && (i_mtvec[1:0] == MTVEC_VECTORED)) begin
      w_target = w_base + {{(XLEN-6){1'b0}}, r_code, 2'b00};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_capture        = 1'b0;
    o_trap_enter     = 1'b0;
    o_trap_exit      = 1'b0;
    o_redirect_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_exc_valid || w_irq_any || i_mret) begin
          w_state_next = ST_DRAIN;
          w_capture    = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (i_pipe_empty || (r_drain_cnt == DRAIN_LAST)) begin
          w_state_next = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        w_state_next = ST_REDIRECT;
        o_trap_enter = ~r_is_mret;
        o_trap_exit  = r_is_mret;
      end
      ST_REDIRECT: begin
        w_state_next     = ST_IDLE;
        o_redirect_valid = 1'b1;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // The drain counter holds the number of DRAIN cycles including the current one.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_is_mret     <= 1'b0;
      r_is_irq      <= 1'b0;
      r_code        <= '0;
      r_drain_cnt   <= '0;
      r_mepc        <= '0;
      r_mcause      <= '0;
      r_mtval       <= '0;
      r_redirect_pc <= '0;
    end else begin
      if (w_capture) begin
        r_drain_cnt <= 4'd1;
        r_is_mret   <= w_take_mret;
        r_is_irq    <= w_take_irq;
        r_code      <= i_exc_valid ? i_exc_cause : w_irq_code;
        if (i_exc_valid) begin
          r_mepc   <= i_exc_pc;
          r_mtval  <= i_exc_tval;
          r_mcause <= XLEN'(make_mcause(1'b0, i_exc_cause));
        end else if (w_irq_any) begin
          r_mepc   <= i_next_pc;
          r_mtval  <= '0;
          r_mcause <= XLEN'(make_mcause(1'b1, w_irq_code));
        end
      end else if (r_state == ST_DRAIN) begin
        r_drain_cnt <= r_drain_cnt + 4'd1;
      end
      if (r_state == ST_COMMIT) begin
        r_redirect_pc <= w_target;
      end
    end
  end

  assign o_flush       = (r_state != ST_IDLE);
  assign o_busy        = (r_state != ST_IDLE);
  assign o_mepc        = r_mepc;
  assign o_mcause      = r_mcause;
  assign o_mtval       = r_mtval;
  assign o_redirect_pc = r_redirect_pc;

endmodule

// File: tb/tb_trap_sequencer.sv
// tb/tb_trap_sequencer.sv - self-checking bench for trap_sequencer with a transaction-level reference model
module tb_trap_sequencer;

  localparam int XLEN = 32;
  localparam int SYNC = 2;
  localparam int DMAX = 15;

  logic            i_clk = 1'b0;
  logic            i_rst_n = 1'b0;
  logic            i_ext_irq = 1'b0, i_sw_irq = 1'b0, i_tmr_irq = 1'b0;
  logic            i_mstatus_mie = 1'b0;
  logic [XLEN-1:0] i_mie = '0, i_mtvec = '0, i_mepc = '0;
  logic            i_exc_valid = 1'b0;
  logic [3:0]      i_exc_cause = '0;
  logic [XLEN-1:0] i_exc_pc = '0, i_exc_tval = '0, i_next_pc = '0;
  logic            i_mret = 1'b0;
  logic            i_pipe_empty = 1'b1;
  logic            o_flush, o_trap_enter, o_trap_exit, o_redirect_valid, o_busy;
  logic [XLEN-1:0] o_mepc, o_mcause, o_mtval, o_redirect_pc;

  trap_sequencer #(.XLEN(XLEN), .SYNC_STAGES(SYNC), .DRAIN_MAX(DMAX)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_ext_irq(i_ext_irq), .i_sw_irq(i_sw_irq), .i_tmr_irq(i_tmr_irq),
    .i_mstatus_mie(i_mstatus_mie), .i_mie(i_mie), .i_mtvec(i_mtvec), .i_mepc(i_mepc),
    .i_exc_valid(i_exc_valid), .i_exc_cause(i_exc_cause), .i_exc_pc(i_exc_pc),
    .i_exc_tval(i_exc_tval), .i_mret(i_mret), .i_next_pc(i_next_pc),
    .i_pipe_empty(i_pipe_empty),
    .o_flush(o_flush), .o_trap_enter(o_trap_enter), .o_trap_exit(o_trap_exit),
    .o_mepc(o_mepc), .o_mcause(o_mcause), .o_mtval(o_mtval),
    .o_redirect_valid(o_redirect_valid), .o_redirect_pc(o_redirect_pc), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a sequence is a numbered run of cycles after the event.
  bit          m_act;
  int          m_t, m_commit;
  bit          m_mret, m_irq;
  logic [3:0]  m_code;
  logic [31:0] m_mepc, m_mtval, m_tgt;
  logic [2:0]  m_hist[$];

  function automatic logic [31:0] f_target(input bit mret, input bit irq, input logic [3:0] code,
                                           input logic [31:0] mtvec, input logic [31:0] mepc);
    if (mret) return mepc & ~32'h3;
    if (irq && mtvec[1:0] == 2'd1) return (mtvec & ~32'h3) + 32'(code) * 4;
    return mtvec & ~32'h3;
  endfunction

  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      chk("rst_flags", 32'({o_flush, o_busy, o_trap_enter, o_trap_exit, o_redirect_valid}), 32'h0);
      chk("rst_mepc", o_mepc, 32'h0);
      chk("rst_mcause", o_mcause, 32'h0);
      chk("rst_redirect_pc", o_redirect_pc, 32'h0);
      m_act = 0;
      m_hist = {};
      for (int i = 0; i < SYNC; i++) m_hist.push_back(3'b000);
    end else begin
      bit e_enter, e_exit, e_redir;
      e_enter = m_act && m_commit != 0 && m_t == m_commit && !m_mret;
      e_exit  = m_act && m_commit != 0 && m_t == m_commit && m_mret;
      e_redir = m_act && m_commit != 0 && m_t == m_commit + 1;
      chk("flush", 32'(o_flush), 32'(m_act));
      chk("busy", 32'(o_busy), 32'(m_act));
      chk("trap_enter", 32'(o_trap_enter), 32'(e_enter));
      chk("trap_exit", 32'(o_trap_exit), 32'(e_exit));
      chk("redirect_valid", 32'(o_redirect_valid), 32'(e_redir));
      if (e_enter) begin
        chk("mepc", o_mepc, m_mepc);
        chk("mcause", o_mcause, (m_irq ? 32'h8000_0000 : 32'h0) | 32'(m_code));
        chk("mtval", o_mtval, m_mtval);
      end
      if (e_redir) chk("redirect_pc", o_redirect_pc, m_tgt);

      if (m_act) begin
        if (m_commit == 0) begin
          if (i_pipe_empty || m_t == DMAX) m_commit = m_t + 1;
        end else if (m_t == m_commit) begin
          m_tgt = f_target(m_mret, m_irq, m_code, i_mtvec, i_mepc);
        end else if (m_t == m_commit + 1) begin
          m_act = 0;
        end
        m_t++;
      end else begin
        logic [2:0] s;
        bit ext, sw, tmr;
        s   = m_hist[0];
        ext = s[2] && i_mie[11] && i_mstatus_mie;
        sw  = s[1] && i_mie[3]  && i_mstatus_mie;
        tmr = s[0] && i_mie[7]  && i_mstatus_mie;
        if (i_exc_valid || ext || sw || tmr || i_mret) begin
          m_act = 1; m_t = 1; m_commit = 0;
          m_mret = 0; m_irq = 0;
          if (i_exc_valid) begin
            m_code = i_exc_cause; m_mepc = i_exc_pc; m_mtval = i_exc_tval;
          end else if (ext || sw || tmr) begin
            m_irq = 1; m_mepc = i_next_pc; m_mtval = 0;
            m_code = ext ? 4'd11 : (sw ? 4'd3 : 4'd7);
          end else begin
            m_mret = 1;
          end
        end
      end
      void'(m_hist.pop_front());
      m_hist.push_back({i_ext_irq, i_sw_irq, i_tmr_irq});
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic wait_for(input int sel, input int budget, input string name, output int at);
    bit hit;
    at = -1;
    for (int i = 0; i < budget && at < 0; i++) begin
      @(negedge i_clk);
      case (sel)
        0:       hit = o_trap_enter;
        1:       hit = o_trap_exit;
        2:       hit = o_redirect_valid;
        default: hit = o_flush;
      endcase
      if (hit) at = cyc;
    end
    n_checks++;
    if (at < 0) begin
      n_fail++;
      $display("FAIL %s: no event within %0d cycles, event required", name, budget);
    end
  endtask

  logic [3:0] causes[6] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd6, 4'd11};

  initial begin
    int n, at, cnt, stall;
    tick(3);
    chk("reset_flags", 32'({o_flush, o_busy, o_trap_enter, o_trap_exit, o_redirect_valid}), 32'h0);
    i_rst_n = 1'b1;
    tick(2);

    // Illegal instruction, pipeline already empty
    i_mtvec = 32'h200; i_exc_valid = 1; i_exc_cause = 4'd2;
    i_exc_pc = 32'h100; i_exc_tval = 32'h0000FFFF; n = cyc;
    tick; i_exc_valid = 0;
    wait_for(0, 10, "illegal_enter", at);
    chk("illegal_enter_cycle", at, n + 2);
    chk("illegal_mepc", o_mepc, 32'h100);
    chk("illegal_mcause", o_mcause, 32'h2);
    chk("illegal_mtval", o_mtval, 32'hFFFF);
    wait_for(2, 4, "illegal_redirect", at);
    chk("illegal_redirect_cycle", at, n + 3);
    chk("illegal_redirect_pc", o_redirect_pc, 32'h200);
    tick(2);

    // Vectored timer interrupt
    i_mtvec = 32'h401; i_mie = 32'h80; i_mstatus_mie = 1; i_next_pc = 32'h80; i_tmr_irq = 1;
    wait_for(0, 10, "tmr_enter", at);
    chk("tmr_mcause", o_mcause, 32'h80000007);
    chk("tmr_mepc", o_mepc, 32'h80);
    chk("tmr_mtval", o_mtval, 32'h0);
    tick; i_mstatus_mie = 0; i_tmr_irq = 0;
    wait_for(2, 4, "tmr_redirect", at);
    chk("tmr_redirect_pc", o_redirect_pc, 32'h41C);
    tick(3);

    // ext + sw + ecall together: ecall first, then ext after MRET
    i_mtvec = 32'h300; i_mie = 32'h808; i_ext_irq = 1; i_sw_irq = 1;
    tick(4);
    i_mstatus_mie = 1; i_exc_valid = 1; i_exc_cause = 4'd11; i_exc_pc = 32'h500; i_exc_tval = 0;
    tick; i_exc_valid = 0;
    wait_for(0, 10, "ecall_enter", at);
    chk("ecall_mcause", o_mcause, 32'hB);
    chk("ecall_mepc", o_mepc, 32'h500);
    tick; i_mstatus_mie = 0;
    wait_for(2, 4, "ecall_redirect", at);
    chk("ecall_redirect_pc", o_redirect_pc, 32'h300);
    tick(2);
    i_mepc = 32'h504; i_mret = 1;
    tick; i_mret = 0;
    wait_for(1, 10, "mret_exit", at);
    tick; i_mstatus_mie = 1;
    wait_for(2, 4, "mret_redirect", at);
    chk("mret_redirect_pc", o_redirect_pc, 32'h504);
    wait_for(0, 12, "ext_enter", at);
    chk("ext_mcause", o_mcause, 32'h8000000B);
    chk("ext_mepc", o_mepc, 32'h80);
    tick; i_mstatus_mie = 0; i_ext_irq = 0; i_sw_irq = 0;
    wait_for(2, 4, "ext_redirect", at);
    chk("ext_redirect_pc", o_redirect_pc, 32'h300);
    tick(4);

    // Global mask holds off a pending timer interrupt
    i_mie = 32'h80; i_tmr_irq = 1; i_mstatus_mie = 0;
    cnt = 0;
    repeat (50) begin
      @(negedge i_clk);
      if (o_flush) cnt++;
    end
    chk("masked_flush_cycles", cnt, 0);
    tick; i_mstatus_mie = 1;
    wait_for(3, SYNC + 2, "unmask_flush", at);
    wait_for(0, 4, "unmask_enter", at);
    tick; i_mstatus_mie = 0; i_tmr_irq = 0;
    tick(4);

    // MRET with a pipeline that never drains: forced commit
    i_pipe_empty = 0; i_mepc = 32'h1237; i_mret = 1; n = cyc;
    tick; i_mret = 0;
    wait_for(1, 30, "forced_exit", at);
    chk("forced_exit_cycle", at, n + 16);
    wait_for(2, 3, "forced_redirect", at);
    chk("forced_redirect_pc", o_redirect_pc, 32'h1234);
    tick(4); i_pipe_empty = 1;
    tick(2);

    // Reset while draining
    i_pipe_empty = 0; i_exc_valid = 1; i_exc_cause = 4'd4; i_exc_pc = 32'h700; i_exc_tval = 32'h703;
    tick; i_exc_valid = 0;
    tick;
    chk("drain_busy", 32'(o_busy), 32'h1);
    i_rst_n = 0;
    #1;
    chk("abort_flags", 32'({o_flush, o_busy, o_trap_enter, o_trap_exit, o_redirect_valid}), 32'h0);
    chk("abort_mepc", o_mepc, 32'h0);
    chk("abort_mtval", o_mtval, 32'h0);
    tick(2); i_rst_n = 1; i_pipe_empty = 1;
    cnt = 0;
    repeat (20) begin
      @(negedge i_clk);
      if (o_trap_enter || o_trap_exit || o_redirect_valid) cnt++;
    end
    chk("post_abort_pulses", cnt, 0);

    // Randomized traffic against the model
    stall = 0;
    for (int k = 0; k < 3000; k++) begin
      tick;
      i_exc_valid = ($urandom_range(0, 15) == 0);
      i_exc_cause = causes[$urandom_range(0, 5)];
      i_exc_pc    = $urandom;
      i_exc_tval  = $urandom;
      i_next_pc   = $urandom;
      i_mepc      = $urandom;
      i_mret      = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0) {i_ext_irq, i_sw_irq, i_tmr_irq} = 3'($urandom);
      if ($urandom_range(0, 31) == 0) begin
        i_mstatus_mie = 1'($urandom);
        i_mie         = $urandom;
        i_mtvec       = $urandom;
      end
      if (stall > 0) begin
        i_pipe_empty = 0;
        stall--;
      end else begin
        i_pipe_empty = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 63) == 0) stall = 20;
      end
    end
    i_exc_valid = 0; i_mret = 0; i_pipe_empty = 1;
    tick(30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
